// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard that stalls decode on RAW hazards
//
// Tracks, for every architectural register, how many cycles remain before a
// pending result may be consumed, and holds off issue of any instruction whose
// source operands are still pending.
//
// Optional feature macro: FORWARDING_EN
//   defined   : latency = issue_is_load ? LOAD_LAT : ALU_LAT
//   undefined : latency = NOFWD_LAT for every producer (no bypass network)
//
// Ports:
//   clk                          rising-edge clock
//   rst_n                        asynchronous active-low reset
//   issue_valid                  decode has an instruction requesting issue
//   issue_rs / issue_rt          source register indices
//   issue_uses_rs / issue_uses_rt  source actually read
//   issue_rd / issue_wr_en       destination index and write enable
//   issue_is_load                producer is a load
//   flush                        discard all pending state (priority over issue)
//   issue_ready                  combinational; 0 stalls decode this cycle
//   pend_mask                    per-register nonzero-countdown flags
//   busy                         any register pending
//   stall_count                  saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 2,
  parameter int ALU_LAT   = 0,
  parameter int LOAD_LAT  = 1,
  parameter int NOFWD_LAT = 2,
  parameter int SC_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic             issue_uses_rs,
  input  logic             issue_uses_rt,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_wr_en,
  input  logic             issue_is_load,
  input  logic             flush,
  output logic             issue_ready,
  output logic [NREGS-1:0] pend_mask,
  output logic             busy,
  output logic [SC_W-1:0]  stall_count
);

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [SC_W-1:0]  stall_count_q;
  logic [SC_W-1:0]  stall_count_d;

  logic [CNT_W-1:0] lat;
  logic             rs_pend;
  logic             rt_pend;
  logic             hazard;
  logic             fire;
  logic             stalled;

  assign lat = FWD ? (issue_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT))
                   : CNT_W'(NOFWD_LAT);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pend_mask[r] = |cnt_q[r];
    end
  end

  // Index by compare-and-select so that indices >= NREGS simply match
  // nothing and read as not pending.
  always_comb begin
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (issue_rs == REG_W'(r)) rs_pend = pend_mask[r];
      if (issue_rt == REG_W'(r)) rt_pend = pend_mask[r];
    end
  end

  assign hazard      = issue_valid & ((issue_uses_rs & rs_pend) | (issue_uses_rt & rt_pend));
  assign issue_ready = ~hazard;
  assign fire        = issue_valid & issue_ready & ~flush;
  assign stalled     = issue_valid & ~issue_ready;

  // Every counter decays by one; a firing producer raises its destination to
  // max(decayed value, latency) so the longer of two WAW producers wins.
  // Register 0 never leaves zero.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - 1'b1;
      if (flush) begin
        cnt_d[r] = '0;
      end else if (fire && issue_wr_en && (issue_rd == REG_W'(r)) && (lat > cnt_d[r])) begin
        cnt_d[r] = lat;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stalled && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign busy        = |pend_mask;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef FORWARDING_EN
  localparam int ALU_L  = 0;
  localparam int LOAD_L = 1;
`else
  localparam int ALU_L  = 2;
  localparam int LOAD_L = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_uses_rs;
  logic        issue_uses_rt;
  logic [4:0]  issue_rd;
  logic        issue_wr_en;
  logic        issue_is_load;
  logic        flush;
  logic        issue_ready;
  logic [31:0] pend_mask;
  logic        busy;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;
  int exp_sc = 0;
  int stalls;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_uses_rs (issue_uses_rs),
    .issue_uses_rt (issue_uses_rt),
    .issue_rd      (issue_rd),
    .issue_wr_en   (issue_wr_en),
    .issue_is_load (issue_is_load),
    .flush         (flush),
    .issue_ready   (issue_ready),
    .pend_mask     (pend_mask),
    .busy          (busy),
    .stall_count   (stall_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rt      = '0;
    issue_uses_rs = 1'b0;
    issue_uses_rt = 1'b0;
    issue_rd      = '0;
    issue_wr_en   = 1'b0;
    issue_is_load = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Present an instruction, count cycles with issue_ready low (bounded),
  // then let it fire on the following edge.
  task automatic run_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                           input logic [4:0] rd, input logic wr, input logic ld,
                           output int n);
    issue_valid   = 1'b1;
    issue_rs      = rs;
    issue_rt      = rt;
    issue_uses_rs = 1'b1;
    issue_uses_rt = urt;
    issue_rd      = rd;
    issue_wr_en   = wr;
    issue_is_load = ld;
    flush         = 1'b0;
    n = 0;
    #1;
    while (!issue_ready && n < 10) begin
      n++;
      step();
    end
    step();
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;

    // Reset held with random stimulus: nothing may change.
    for (int i = 0; i < 4; i++) begin
      issue_valid   = 1'($urandom);
      issue_rs      = 5'($urandom);
      issue_rt      = 5'($urandom);
      issue_uses_rs = 1'b1;
      issue_uses_rt = 1'b1;
      issue_rd      = 5'($urandom);
      issue_wr_en   = 1'b1;
      issue_is_load = 1'($urandom);
      flush         = 1'($urandom);
      step();
      check_eq("rst_ready", issue_ready, 1);
      check_eq("rst_pend", pend_mask, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_sc", stall_count, 0);
    end
    set_idle();
    step();
    rst_n = 1'b1;
    idle(2);
    check_eq("post_rst_pend", pend_mask, 0);
    check_eq("post_rst_sc", stall_count, 0);

    // addi R1,R0,8 ; add R10,R5,R1
    run_instr(5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, stalls);
    check_eq("alu_prod_stall", stalls, 0);
    run_instr(5'd5, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, stalls);
    check_eq("alu_use_stall", stalls, ALU_L);
    exp_sc += ALU_L;
    check_eq("alu_sc", stall_count, exp_sc);
    idle(4);
    check_eq("alu_drain_busy", busy, 0);

    // LW R6,8(R0) ; or R9,R6,R3
    run_instr(5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, stalls);
    check_eq("lw_prod_stall", stalls, 0);
    check_eq("lw_pend6", pend_mask[6], 1);
    check_eq("lw_busy", busy, 1);
    run_instr(5'd6, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, stalls);
    check_eq("load_use_stall", stalls, LOAD_L);
    exp_sc += LOAD_L;
    check_eq("load_sc", stall_count, exp_sc);
    idle(4);

    // sub R8,R1,R2 ; and R12,R7,R2 ; slt R13,R8,R12
    run_instr(5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, stalls);
    check_eq("sub_stall", stalls, 0);
    run_instr(5'd7, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, stalls);
    check_eq("indep_stall", stalls, 0);
    run_instr(5'd8, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, stalls);
    check_eq("slt_stall", stalls, ALU_L);
    exp_sc += ALU_L;
    check_eq("slt_sc", stall_count, exp_sc);
    idle(4);
    check_eq("drain_pend", pend_mask, 0);

    // Flush while a dependent on R6 waits.
    run_instr(5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, stalls);
    issue_valid   = 1'b1;
    issue_rs      = 5'd6;
    issue_uses_rs = 1'b1;
    #1;
    check_eq("flush_dep_ready_pre", issue_ready, 0);
    flush = 1'b1;
    step();
    exp_sc += 1;
    check_eq("flush_pend", pend_mask, 0);
    flush = 1'b0;
    #1;
    check_eq("flush_dep_ready_post", issue_ready, 1);
    step();
    set_idle();
    check_eq("flush_sc", stall_count, exp_sc);

    // Flush wins over a firing producer.
    issue_valid   = 1'b1;
    issue_rs      = 5'd0;
    issue_uses_rs = 1'b1;
    issue_rd      = 5'd4;
    issue_wr_en   = 1'b1;
    issue_is_load = 1'b1;
    flush         = 1'b1;
    step();
    set_idle();
    check_eq("flush_prio_pend", pend_mask, 0);

    // addi R0,R0,1 never creates pending state.
    run_instr(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, stalls);
    check_eq("r0_pend", pend_mask, 0);

    // WAW: LW R6 then ALU op writing R6, then a reader of R6.
    run_instr(5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, stalls);
    run_instr(5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, stalls);
    check_eq("waw_pend6", pend_mask[6], ((LOAD_L - 1 > ALU_L ? LOAD_L - 1 : ALU_L) != 0));
    run_instr(5'd6, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, stalls);
    check_eq("waw_use_stall", stalls, (LOAD_L - 1 > ALU_L ? LOAD_L - 1 : ALU_L));
    exp_sc += (LOAD_L - 1 > ALU_L ? LOAD_L - 1 : ALU_L);
    check_eq("waw_sc", stall_count, exp_sc);
    idle(4);

    // Reset asserted mid-stall: ready returns without a clock edge.
    run_instr(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, stalls);
    issue_valid   = 1'b1;
    issue_rs      = 5'd7;
    issue_uses_rs = 1'b1;
    #1;
    check_eq("midrst_ready_pre", issue_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", issue_ready, 1);
    check_eq("midrst_pend", pend_mask, 0);
    check_eq("midrst_sc", stall_count, 0);
    step();
    rst_n = 1'b1;
    set_idle();
    idle(2);
    check_eq("after_rst_sc", stall_count, 0);
    check_eq("after_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-dependency scoreboard for the pipelined CPU's decode stage. It generalises the hazard detection unit to any register-file size and any producer latency. It tracks, per architectural register, how many cycles remain before a pending result can be consumed, and stalls issue of any instruction whose source operands are not yet available. Load-use and ALU-use latencies are independent parameters, and operand forwarding is a compile-time option.

## Interface
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_W, 5, register index width; must satisfy 2**REG_W >= NREGS.
- CNT_W, 2, per-register countdown width; must hold the largest latency.
- ALU_LAT, 0, stall cycles after a non-load producer when forwarding is compiled in.
- LOAD_LAT, 1, stall cycles after a load producer when forwarding is compiled in.
- NOFWD_LAT, 2, stall cycles after any producer when forwarding is compiled out.
- SC_W, 16, stall counter width.

- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; asserted when 0.
- issue_valid  in  1  an instruction in decode requests issue.
- issue_rs, issue_rt  in  REG_W each  source register indices.
- issue_uses_rs, issue_uses_rt  in  1 each  source actually read.
- issue_rd  in  REG_W  destination register index.
- issue_wr_en  in  1  instruction writes issue_rd.
- issue_is_load  in  1  instruction is a load (LW).
- flush  in  1  discard all pending state (branch/exception).
- issue_ready  out  1  combinational; 0 = stall decode this cycle.
- pend_mask  out  NREGS  bit r set when the countdown for register r is nonzero; registered.
- busy  out  1  OR-reduction of pend_mask.
- stall_count  out  SC_W  saturating count of stalled cycles.

## Operation
- State: cnt[r], CNT_W bits, for r = 1..NREGS-1. cnt[0] is constant 0.
- hazard = issue_valid & ((issue_uses_rs & cnt[issue_rs]!=0) | (issue_uses_rt & cnt[issue_rt]!=0)).
- issue_ready = ~hazard. fire = issue_valid & issue_ready & ~flush.
- An instruction never hazards against its own issue_rd.
- Each edge, every nonzero cnt decrements by 1.
- On fire with issue_wr_en and issue_rd != 0: L is the latency for the instruction type. cnt[issue_rd] <= max(cnt[issue_rd]-1 saturated at 0, L). For write-after-write hazards the longer remaining latency wins.
- If L = 0, no pending state is created.
- flush: all cnt cleared at the next edge. Any issue in the same cycle is ignored for scoreboard update; flush has priority.
- stall_count increments on every cycle with issue_valid & ~issue_ready and saturates at all-ones. Reset is the only way to clear it; flush does not clear it.
- Out-of-range indices (index >= NREGS) read as not pending. Writes to them are ignored.

## Timing
- Reset (Reset=0, asynchronous): all cnt=0, pend_mask=0, busy=0, stall_count=0. issue_ready=1 regardless of issue_valid.
- Reset asserted mid-stall: pending state is lost immediately, and issue_ready goes to 1 without waiting for a clock edge.
- Example: producer fires at cycle t with latency L; the dependent is presented from t+1. issue_ready=0 for cycles t+1..t+L and 1 at t+1+L.
- pend_mask and busy reflect cnt after the edge, with no further delay.
- issue_ready has zero latency from the inputs (combinational path from issue_* through the cnt read mux).

## Configuration
- FORWARDING_EN defined: L = issue_is_load ? LOAD_LAT : ALU_LAT. With the defaults, ALU→use needs no stall and load→use costs 1 stall.
- FORWARDING_EN undefined: L = NOFWD_LAT for every producer, so both loads and ALU ops cost 2 stalls by default. This models write-back-then-read with no bypass.

## Test plan
- Reset check. Hold Reset=0 and drive random inputs → pend_mask=0, busy=0, stall_count=0, issue_ready=1. Release Reset → state unchanged until the first fire.
- ALU chain, FORWARDING_EN. Issue addi R1,R0,8, then add R10,R5,R1 → zero stall cycles, stall_count=0, pend_mask stays 0.
- Load-use, FORWARDING_EN. Issue LW R6,8(R0), then or R9,R6,R3 → issue_ready=0 for exactly 1 cycle, pend_mask[6]=1 for 1 cycle, stall_count=1.
- No forwarding, FORWARDING_EN undefined. Issue sub R8,R1,R2, then slt R13,R8,R12 → 2 stall cycles, stall_count=2. An independent instruction (and R12,R7,R2) issued meanwhile proceeds with no stall.
- Flush. Issue LW R6, then assert flush for 1 cycle while a dependent on R6 is waiting → pend_mask=0 after that edge and the dependent is ready the next cycle. A write to R0 (addi R0,R0,1) never sets pend_mask.
- Write-after-write and reset: LW R6 (L=1) followed by an ALU op writing R6 (L=0) → cnt[6] keeps the longer latency. Assert Reset mid-stall → issue_ready=1 immediately.
